// File: rtl/min_reduce_int64_if.sv
// Operand/result stream bundle for min_reduce_int64.
// out_idx exists only when MIN_REDUCE_ARGMIN_EN is defined.
interface min_reduce_int64_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned IDX_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_min;
   logic [IDX_W-1:0] out_count;
`ifdef MIN_REDUCE_ARGMIN_EN
   logic [IDX_W-1:0] out_idx;
`endif

   // Producer/consumer side (testbench or upstream/downstream logic)
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_min, out_count
`ifdef MIN_REDUCE_ARGMIN_EN
      , input out_idx
`endif
   );

   // Reduction stage side
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_min, out_count
`ifdef MIN_REDUCE_ARGMIN_EN
      , output out_idx
`endif
   );
endinterface

// File: rtl/min_reduce_int64.sv
// Streaming signed min-reduction: one result (min, count[, argmin]) per frame.
// Define MIN_REDUCE_ARGMIN_EN to build the position/argmin logic and out_idx.
module min_reduce_int64 #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned IDX_W = 16
) (
   input logic               clk,
   input logic               rst_n,
   min_reduce_int64_if.slave bus
);
   localparam logic [IDX_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ACC   = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             accept_c;
   logic [IDX_W-1:0] cnt_inc_c;
`ifdef MIN_REDUCE_ARGMIN_EN
   logic [IDX_W-1:0] pos_q, pos_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] pos_inc_c;
`endif

   assign accept_c  = bus.in_valid && in_ready_q;
   assign cnt_inc_c = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + IDX_W'(1);
`ifdef MIN_REDUCE_ARGMIN_EN
   assign pos_inc_c = (pos_q == CNT_MAX) ? CNT_MAX : pos_q + IDX_W'(1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
`ifdef MIN_REDUCE_ARGMIN_EN
         pos_q       <= '0;
         idx_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
`ifdef MIN_REDUCE_ARGMIN_EN
         pos_q       <= pos_d;
         idx_q       <= idx_d;
`endif
      end
   end

   // Next state and datapath; handshake flags follow the next state so they are registered
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
`ifdef MIN_REDUCE_ARGMIN_EN
      pos_d   = pos_q;
      idx_d   = idx_q;
`endif
      unique case (state_q)
         EMPTY: begin
            if (accept_c) begin
               acc_d   = bus.in_data;
               cnt_d   = IDX_W'(1);
`ifdef MIN_REDUCE_ARGMIN_EN
               pos_d   = '0;
               idx_d   = '0;
`endif
               state_d = bus.in_last ? DONE : ACC;
            end
         end
         ACC: begin
            if (accept_c) begin
               // Strict greater-than: ties keep the earlier element
               if ($signed(acc_q) > $signed(bus.in_data)) begin
                  acc_d = bus.in_data;
`ifdef MIN_REDUCE_ARGMIN_EN
                  idx_d = pos_inc_c;
`endif
               end
               cnt_d = cnt_inc_c;
`ifdef MIN_REDUCE_ARGMIN_EN
               pos_d = pos_inc_c;
`endif
               if (bus.in_last) state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
      in_ready_d  = (state_d != DONE);
      out_valid_d = (state_d == DONE);
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_min   = acc_q;
   assign bus.out_count = cnt_q;
`ifdef MIN_REDUCE_ARGMIN_EN
   assign bus.out_idx   = idx_q;
`endif
endmodule

// File: doc/min_reduce_int64.md
# min_reduce_int64

Streaming signed-integer min-reduction stage. It consumes a frame of 64-bit two's-complement operands over a valid/ready stream and reduces them pairwise with a running-minimum register. Each step uses the same "keep A unless A > B" rule as the combinational min benchmark. It emits one result per frame and sits directly downstream of the combinational min/compare benchmarks, as the sequential reduction wrapper used for multi-operand min workloads.

## Interface
- WIDTH, 64, operand width in bits; operands are signed two's complement.
- IDX_W, 16, width of the element counter and the argmin index.

Ports, clock and reset first:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  stage can accept a beat; registered.
- in_data  input  WIDTH  signed operand.
- in_last  input  1  final beat of the current frame.
- out_valid  output  1  frame result valid; registered.
- out_ready  input  1  downstream accepts the result.
- out_min  output  WIDTH  minimum of the frame, signed.
- out_count  output  IDX_W  number of beats in the frame; saturating.
- out_idx  output  IDX_W  zero-based position of the minimum; present only with MIN_REDUCE_ARGMIN_EN.

## Operation
- Accept: a beat is transferred when in_valid && in_ready at a rising clk.
- States: EMPTY (no beat accepted in the current frame), ACC (at least one beat held), DONE (result presented).
- EMPTY, on accept: acc <= in_data; pos <= 0; cnt <= 1. If in_last, go to DONE; otherwise go to ACC.
- ACC, on accept: if signed(acc) > signed(in_data), then acc <= in_data and idx <= pos+1.
  - Ties keep the earlier element, so idx reports the first occurrence.
  - pos increments; cnt increments.
  - If in_last, go to DONE.
- DONE: in_ready = 0; out_valid = 1, with out_min/out_count/out_idx stable. On out_ready, go to EMPTY.
- Comparison is full-width signed. 0x8000_0000_0000_0000 is the smallest value; 0x7FFF_FFFF_FFFF_FFFF is the largest.
- Saturation: cnt and pos saturate at 2^IDX_W−1 and never wrap.
  - A new minimum found after saturation reports idx = 2^IDX_W−1.
- in_data and in_last are ignored when in_valid && in_ready is not true.
- No in-band frame abort. Only rst_n discards a partial frame.

## Timing
- Reset values, while rst_n is low and at deassertion:
  - state = EMPTY; in_ready = 0; out_valid = 0.
  - out_min = 0; out_count = 0; out_idx = 0; acc, pos, cnt = 0.
- in_ready rises on the first rising clk after rst_n deasserts.
- Throughput: one beat per cycle while in EMPTY/ACC.
- Latency: out_valid rises on the same edge that accepts the in_last beat, so it is visible in the following cycle.
  - in_ready falls on that same edge. No beat of the next frame is accepted while out_valid = 1.
- Output handshake: the result completes on the edge where out_valid && out_ready.
  - That edge clears out_valid and sets in_ready.
  - No same-cycle bypass: the minimum gap between the last beat of frame N and the first beat of frame N+1 is 2 cycles when out_ready is held high.
- out_valid, once high, stays high with stable data until the handshake completes.
- Reset mid-frame or mid-DONE: all outputs return to their reset values immediately (asynchronous). The partial frame or pending result is lost.

## Configuration
- MIN_REDUCE_ARGMIN_EN defined:
  - the out_idx port exists;
  - the pos/idx registers are built;
  - idx is updated as described in Operation.
- Not defined:
  - the out_idx port is absent and there is no index logic;
  - out_min, out_count and the handshake are cycle-identical to the defined build.

## Test plan
- Single-beat frame: in_data = 0xFFFF_FFFF_FFFF_FFFB (−5) with in_last → next cycle out_min = −5, out_count = 1, out_idx = 0.
- Signed ordering: frame {5, −1, 0x8000_0000_0000_0000, 7} → out_min = 0x8000_0000_0000_0000, out_count = 4, out_idx = 2.
- Tie and first occurrence: {3, −2, 9, −2} → out_min = −2, out_idx = 1.
- Backpressure: hold out_ready = 0 for 5 cycles after the result.
  - Required: in_ready = 0 and out_min stable throughout.
  - Release out_ready → in_ready = 1 the next cycle; a back-to-back second frame {10, 4} → out_min = 4.
- Bubbles: frame {6, 2, 8} sent with in_valid deasserted between beats → out_min = 2, out_count = 3.
- Reset mid-frame: accept {−9, 1}, pull rst_n low → out_valid = 0 and in_ready = 0 immediately. After release, frame {4} → out_min = 4, out_count = 1 (no residue from −9).
